// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b), LSB first, one bit per clock.
// Optional signed-overflow flag built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds only the upper WIDTH-1 result bits; the final bit joins them on DONE entry.
  logic [WIDTH-2:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             x, y, d, br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    x        = a_sr[0];
    y        = b_sr[0];
    d        = x ^ y ^ br;
    br_next  = (~x & y) | (~(x ^ y) & br);
    res_next = {d, r_sr};
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would let later statements see updated values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= res_next[WIDTH-1:1];
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            diff   <= res_next;
            borrow <= br_next;
            zero   <= (res_next == '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  // Overflow uses the operand MSBs captured at acceptance and the final result bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == RUN && cnt == LAST)
        ovf <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH = 8), with
// hand-written sequences for busy-ignore, held start and mid-operation reset.
module tb_serial_subtractor;

  localparam int W = 8;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge: inputs are driven and outputs sampled here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;   // value with the overflow feature enabled
  } vec_t;

  vec_t vecs[7];

  logic [W-1:0] held_diff;
  logic         held_borrow, held_zero, held_ovf;

  // Caller is in an IDLE cycle; this cycle becomes cycle 0 of the operation.
  task automatic run_op(input vec_t v, input string tag);
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    for (int k = 1; k <= W + 1; k++) begin
      tick();
      if (k == 1) begin
        start = 1'b0;
        a     = ~v.a;
        b     = ~v.b;
      end
      check({tag, " busy"}, busy, 1);
      check({tag, " done"}, done, (k == W + 1));
      if (k == 1 || k == W) begin
        check({tag, " hold diff"},   diff,   held_diff);
        check({tag, " hold borrow"}, borrow, held_borrow);
        check({tag, " hold zero"},   zero,   held_zero);
        check({tag, " hold ovf"},    ovf,    held_ovf);
      end
    end
    check({tag, " diff"},   diff,   v.diff);
    check({tag, " borrow"}, borrow, v.borrow);
    check({tag, " zero"},   zero,   v.zero);
    check({tag, " ovf"},    ovf,    v.ovf & OVF_EN);
    held_diff   = v.diff;
    held_borrow = v.borrow;
    held_zero   = v.zero;
    held_ovf    = v.ovf & OVF_EN;
    tick();
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle done"}, done, 0);
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h33, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("reset busy",   busy,   0);
    check("reset done",   done,   0);
    check("reset diff",   diff,   0);
    check("reset borrow", borrow, 0);
    check("reset zero",   zero,   0);
    check("reset ovf",    ovf,    0);
    rst = 1'b0;
    held_diff = '0; held_borrow = 1'b0; held_zero = 1'b0; held_ovf = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // start pulsed while busy is ignored and not queued
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    for (int k = 1; k <= W + 3; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      if (k == 4) start = 1'b0;
      check("ignore done", done, (k == W + 1));
      if (k == W + 1) begin
        check("ignore diff",   diff,   8'h1E);
        check("ignore borrow", borrow, 0);
      end
      if (k > W + 1) check("ignore no requeue busy", busy, 0);
    end

    // start held high: one operation every W+2 cycles
    start = 1'b1; a = 8'h02; b = 8'h01;
    for (int c = 1; c <= 31; c++) begin
      tick();
      if (c == 30) start = 1'b0;
      check("held done", done, (c == 9 || c == 19 || c == 29));
      check("held busy", busy, !(c % 10 == 0 || c == 31));
      if (c == 9 || c == 19 || c == 29) begin
        check("held diff",   diff,   8'h01);
        check("held borrow", borrow, 0);
      end
    end

    // reset in cycle 4 aborts the operation
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        check("abort diff",   diff,   0);
        check("abort borrow", borrow, 0);
        check("abort zero",   zero,   0);
        check("abort ovf",    ovf,    0);
      end
      if (k >= 5) begin
        check("abort busy", busy, 0);
        check("abort done", done, 0);
      end
    end

    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1; a = 8'h07; b = 8'h09;
    tick();
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst+start busy", busy, 0);
      check("rst+start done", done, 0);
      tick();
    end

    held_diff = '0; held_borrow = 1'b0; held_zero = 1'b0; held_ovf = 1'b0;
    run_op('{8'h07, 8'h09, 8'hFE, 1'b1, 1'b0, 1'b0}, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
